instruction_fetch: RTL

Front-end fetch stage of the RISC-V core: generates sequential PCs, issues requests to instruction memory, buffers returned words with their PCs in a small prefetch queue, and presents them to the operand-fetch stage as `pc_out`/`instruction_out`. It is the producer side of the operand-fetch input interface and obeys that stage's `halt` stall. Branch and jump redirects flush the queue and discard responses still in flight.

---
 rtl/instruction_fetch_if.sv | 21 ++
 rtl/instruction_fetch.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and instruction memory (slave).
interface instruction_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: sequential PC generation, in-order imem requests, prefetch queue,
// redirect flush with in-flight discard. Optional IFETCH_MISALIGN_TRAP_EN adds a sticky fault.
module instruction_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                halt,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  instruction_fetch_if.master imem,
  output logic                valid_out,
  output logic [XLEN-1:0]     pc_out,
  output logic [XLEN-1:0]     instruction_out
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic                misaligned_fault
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] qpc_q [DEPTH];
  logic [XLEN-1:0] qpc_d [DEPTH];
  logic [XLEN-1:0] qins_q [DEPTH];
  logic [XLEN-1:0] qins_d [DEPTH];
  logic [PW-1:0]   qrd_q, qrd_d, qwr_q, qwr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pcf_q [DEPTH];
  logic [XLEN-1:0] pcf_d [DEPTH];
  logic [PW-1:0]   prd_q, prd_d, pwr_q, pwr_d;
  logic [CW-1:0]   pcnt_q, pcnt_d;
  logic [CW-1:0]   inflight_q, inflight_d, discard_q, discard_d;

  logic            issue_ok, accept, rsp_drop, rsp_take, deq;
  logic            q_push, pcf_push, pcf_pop;
  logic [XLEN-1:0] rsp_pc;
  logic [CW:0]     occupancy;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign issue_ok         = !fault_q;
  assign misaligned_fault = fault_q;
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) fault_d = |redirect_pc[1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
`else
  logic unused_pc_lsb;
  assign issue_ok      = 1'b1;
  assign unused_pc_lsb = |redirect_pc[1:0];
`endif

  // inflight includes responses still to be discarded, so it alone bounds memory traffic
  assign occupancy           = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem.imem_req_valid = rst_n && issue_ok && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem.imem_req_addr  = fetch_pc_q;

  assign valid_out       = (count_q != '0);
  assign pc_out          = valid_out ? qpc_q[qrd_q]  : '0;
  assign instruction_out = valid_out ? qins_q[qrd_q] : XLEN'(32'h0000_0013);

  assign accept   = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_drop = imem.imem_rsp_valid && (discard_q != '0);
  assign rsp_take = imem.imem_rsp_valid && (discard_q == '0) && !redirect_valid;
  assign deq      = valid_out && !halt && !redirect_valid;
  assign q_push   = rsp_take;
  // An empty PC FIFO with a live response means a zero-latency reply to this cycle's request
  assign rsp_pc   = (pcnt_q == '0) ? fetch_pc_q : pcf_q[prd_q];
  assign pcf_push = accept && !(rsp_take && pcnt_q == '0);
  assign pcf_pop  = rsp_take && (pcnt_q != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    qpc_d      = qpc_q;
    qins_d     = qins_q;
    qrd_d      = qrd_q;
    qwr_d      = qwr_q;
    count_d    = count_q;
    pcf_d      = pcf_q;
    prd_d      = prd_q;
    pwr_d      = pwr_q;
    pcnt_d     = pcnt_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(accept) - CW'(imem.imem_rsp_valid);

    if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);

    if (redirect_valid) begin
      qrd_d      = '0;
      qwr_d      = '0;
      count_d    = '0;
      prd_d      = '0;
      pwr_d      = '0;
      pcnt_d     = '0;
      discard_d  = inflight_d;
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      if (rsp_drop) discard_d = discard_q - CW'(1);
      if (pcf_push) begin
        pcf_d[pwr_q] = fetch_pc_q;
        pwr_d        = pwr_q + PW'(1);
      end
      if (pcf_pop) prd_d = prd_q + PW'(1);
      pcnt_d = pcnt_q + CW'(pcf_push) - CW'(pcf_pop);
      if (q_push) begin
        qpc_d[qwr_q]  = rsp_pc;
        qins_d[qwr_q] = imem.imem_rsp_data;
        qwr_d         = qwr_q + PW'(1);
      end
      if (deq) qrd_d = qrd_q + PW'(1);
      count_d = count_q + CW'(q_push) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        qpc_q[i]  <= '0;
        qins_q[i] <= '0;
        pcf_q[i]  <= '0;
      end
      qrd_q      <= '0;
      qwr_q      <= '0;
      count_q    <= '0;
      prd_q      <= '0;
      pwr_q      <= '0;
      pcnt_q     <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      qpc_q      <= qpc_d;
      qins_q     <= qins_d;
      qrd_q      <= qrd_d;
      qwr_q      <= qwr_d;
      count_q    <= count_d;
      pcf_q      <= pcf_d;
      prd_q      <= prd_d;
      pwr_q      <= pwr_d;
      pcnt_q     <= pcnt_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  a_queue_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(!redirect_valid && q_push && !deq && count_q == CW'(DEPTH)));
  a_pcf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(!redirect_valid && pcf_push && !pcf_pop && pcnt_q == CW'(DEPTH)));
endmodule
